aes_key_expand: RTL and testbench
=================================

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have no parameters; AES-128 only, 10 rounds, 11 round keys.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_start  input  1  start request, sampled only in IDLE.
REQ-005 i_key  input  128  cipher key; [127:96] = w0, [31:0] = w3, MSB byte first in each word.
REQ-006 i_rk_ready  input  1  consumer ready for current round key (present only with KEY_EXPAND_STALL_EN).
REQ-007 o_busy  output  1  high from start acceptance until the cycle after the final key transfer.
REQ-008 o_rk_valid  output  1  o_rk and o_rk_idx hold a valid round key.
REQ-009 o_rk_idx  output  4  round-key index 0..10.
REQ-010 o_rk  output  128  round key, same word/byte layout as i_key.
REQ-011 o_done  output  1  one-cycle pulse coinciding with the transfer of round key 10.

Function
REQ-012 SHALL implement states IDLE, EXPAND; IDLE->EXPAND on i_start=1; EXPAND->IDLE on transfer of index 10.
REQ-013 Start accepted in IDLE SHALL register i_key; next cycle o_rk_valid=1, o_rk_idx=0, o_rk=i_key.
REQ-014 A transfer SHALL occur on each cycle with o_rk_valid=1 (and i_rk_ready=1 when stall is compiled in).
REQ-015 On each transfer with idx<10, next cycle SHALL present idx+1 with key derived from the current o_rk.
REQ-016 Derivation: t = SubWord(RotWord(w3)) XOR {Rcon[idx+1],24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-017 RotWord SHALL map bytes [b0 b1 b2 b3] to [b1 b2 b3 b0]; SubWord SHALL apply four instances of the AES forward S-box module combinationally.
REQ-018 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36 (GF(2^8) doubling, reduction poly 0x11b).
REQ-019 One round key per cycle without stall: key idx n valid n+1 cycles after start acceptance; o_done at cycle 11.
REQ-020 i_start while o_busy=1 SHALL be ignored; i_key changes after acceptance SHALL have no effect.
REQ-021 Transfer of idx 10 SHALL drive o_rk_valid=0 next cycle; o_rk/o_rk_idx SHALL retain last values.
REQ-022 i_start asserted in the cycle after o_done SHALL be accepted (back-to-back expansions).

Reset
REQ-023 i_rst_n=0 at a clock edge SHALL force IDLE, o_busy=0, o_rk_valid=0, o_done=0, o_rk_idx=0, o_rk=0.
REQ-024 Reset mid-expansion SHALL abort immediately; no further round keys; i_start in the reset cycle ignored.
REQ-025 Reset SHALL take precedence over i_start and i_rk_ready in the same cycle.

Configuration
REQ-026 Macro KEY_EXPAND_STALL_EN defined: i_rk_ready port exists; o_rk_valid=1 with i_rk_ready=0 SHALL hold o_rk, o_rk_idx stable and keep o_rk_valid=1; o_done only on the actual idx-10 transfer.
REQ-027 Macro undefined: no i_rk_ready port; every o_rk_valid cycle is a transfer; 11-cycle fixed latency per REQ-019.

Verification
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c, start -> idx1 a0fafe1788542cb123a339392a6c7605; idx10 d014f9a8c9ee2589e13f0cc8b6630ca6 with o_done=1.
REQ-029 Key 0, start -> idx1 62636363626363636263636362636363; idx10 b4ef5bcb3e92e21123e951cf6f8f188e; o_rk_idx steps 0..10 on consecutive cycles.
REQ-030 i_start pulsed at idx 4 with different i_key -> sequence unchanged, o_done once at cycle 11.
REQ-031 i_rst_n=0 while idx=6 -> next cycle o_rk_valid=0, o_busy=0, o_rk=0, no o_done; restart yields idx0..10 correctly.
REQ-032 (KEY_EXPAND_STALL_EN) i_rk_ready=0 for 3 cycles at idx 2 -> o_rk stable at idx-2 value, o_rk_valid held; resumes idx3 after ready; final keys match REQ-028.
REQ-033 Start on the cycle after o_done -> second expansion accepted, idx0 equals new i_key.

Source files
------------

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand -- AES-128 key schedule. It produces one round key per cycle
// (indices 0..10) from a 128-bit cipher key.
//
// Optional feature macro: KEY_EXPAND_STALL_EN
//   If defined, the i_rk_ready port exists. A round key transfers only on a
//   cycle where o_rk_valid=1 and i_rk_ready=1. While the consumer stalls,
//   o_rk and o_rk_idx hold their values.
//   If undefined, every cycle with o_rk_valid=1 is a transfer, and key n
//   appears n+1 cycles after the start is accepted.
//
// Ports
//   i_clk       sole clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_start     start request, sampled only while idle
//   i_key       cipher key, [127:96] = w0 ... [31:0] = w3
//   i_rk_ready  consumer ready (KEY_EXPAND_STALL_EN only)
//   o_busy      high while an expansion is in flight
//   o_rk_valid  o_rk / o_rk_idx hold a valid round key
//   o_rk_idx    round-key index 0..10
//   o_rk        round key, same layout as i_key
//   o_done      one-cycle pulse on the transfer of round key 10
//
// aes_sbox -- AES forward S-box. It is computed as the GF(2^8) inverse
// (a^254) followed by the affine transform. The design is purely
// combinational.
//   a  input byte
//   s  substituted byte
// -----------------------------------------------------------------------------

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Compute a^254 by square-and-multiply.
    // The exponent bits 7..1 are set and bit 0 is clear.
    // The result maps 0 to 0, which the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, x);
        end
        return r;
    endfunction

    logic [7:0] b;

    always_comb begin
        b = gf_inv(a);
        s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
              ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

endmodule

module aes_key_expand (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [127:0] i_key,
`ifdef KEY_EXPAND_STALL_EN
    input  logic         i_rk_ready,
`endif
    output logic         o_busy,
    output logic         o_rk_valid,
    output logic [3:0]   o_rk_idx,
    output logic [127:0] o_rk,
    output logic         o_done
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    localparam logic [3:0] LAST_IDX = 4'd10;

    logic [0:0]   state_reg, state_next;
    logic [127:0] rk_reg, rk_next;
    logic [3:0]   idx_reg, idx_next;
    logic         valid_reg, valid_next;

    logic         transfer;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  t_word;
    logic [31:0]  w0_new, w1_new, w2_new, w3_new;

    // Round constant for the key that follows index n.
    // The argument is n+1, in the range 1..10.
    function automatic logic [7:0] rcon_of(input logic [3:0] n);
        logic [7:0] rc;
        case (n)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

`ifdef KEY_EXPAND_STALL_EN
    assign transfer = valid_reg & i_rk_ready;
`else
    assign transfer = valid_reg;
`endif

    // RotWord applied to w3: byte order [b0 b1 b2 b3] becomes [b1 b2 b3 b0].
    assign rot_word = {rk_reg[23:0], rk_reg[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_sbox
            aes_sbox u_sbox (
                .a (rot_word[gi*8 +: 8]),
                .s (sub_word[gi*8 +: 8])
            );
        end
    endgenerate

    assign t_word = sub_word ^ {rcon_of(idx_reg + 4'd1), 24'h000000};
    assign w0_new = rk_reg[127:96] ^ t_word;
    assign w1_new = rk_reg[95:64]  ^ w0_new;
    assign w2_new = rk_reg[63:32]  ^ w1_new;
    assign w3_new = rk_reg[31:0]   ^ w2_new;

    always_comb begin
        state_next = state_reg;
        rk_next    = rk_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next = EXPAND;
                    rk_next    = i_key;
                    idx_next   = 4'd0;
                    valid_next = 1'b1;
                end
            end
            EXPAND: begin
                if (transfer) begin
                    if (idx_reg == LAST_IDX) begin
                        // The last key stays on o_rk / o_rk_idx after valid drops.
                        state_next = IDLE;
                        valid_next = 1'b0;
                    end else begin
                        rk_next  = {w0_new, w1_new, w2_new, w3_new};
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            rk_reg    <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rk_reg    <= rk_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
        end
    end

    assign o_busy     = (state_reg == EXPAND);
    assign o_rk_valid = valid_reg;
    assign o_rk_idx   = idx_reg;
    assign o_rk       = rk_reg;
    assign o_done     = transfer & (idx_reg == LAST_IDX);

endmodule

// File: tb/tb_aes_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand -- self-checking bench for aes_key_expand.
// The bench drives random and known-answer keys and compares every round key
// against a word-array model of the AES-128 key schedule. That model uses a
// table S-box.
// -----------------------------------------------------------------------------

module tb_aes_key_expand;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [127:0] KAT1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KAT1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KAT1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KAT2_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KAT2_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam int           BUDGET    = 200;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         done;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_exp = 0;
    logic [127:0] model_rk [11];
    logic [127:0] seen_rk1;
    logic [127:0] seen_rk10;

    always #5 clk = ~clk;

    aes_key_expand dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_key      (key_in),
`ifdef KEY_EXPAND_STALL_EN
        .i_rk_ready (rk_ready),
`endif
        .o_busy     (busy),
        .o_rk_valid (rk_valid),
        .o_rk_idx   (rk_idx),
        .o_rk       (rk),
        .o_done     (done)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // One clock: return 1 time unit after the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // AES-128 key schedule over a 44-word array.
    task automatic build_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // mode 0: always ready, 1: random stalls, 2: three stall cycles at idx 2.
    task automatic run_expand(input logic [127:0] key, input int mode, input bit mid_start);
        int n;
        int stalled;
        int budget;
        build_model(key);
        key_in = key;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        key_in = rand_key();
        n = 0;
        stalled = 0;
        budget = 0;
        while (n <= 10 && budget < BUDGET) begin
            rk_ready = 1'b1;
            if (mode == 1 && $urandom_range(0, 2) == 0) rk_ready = 1'b0;
            if (mode == 2 && n == 2 && stalled < 3) begin
                rk_ready = 1'b0;
                stalled++;
            end
`ifndef KEY_EXPAND_STALL_EN
            rk_ready = 1'b1;
`endif
            if (mid_start && n == 4) begin
                start  = 1'b1;
                key_in = rand_key();
            end else begin
                start = 1'b0;
            end
            #1;
            check_val("valid", {127'b0, rk_valid}, 128'd1);
            check_val("idx", {124'b0, rk_idx}, 128'(n));
            check_val("rk", rk, model_rk[n]);
            check_val("busy", {127'b0, busy}, 128'd1);
            check_val("done", {127'b0, done}, {127'b0, (n == 10) && rk_ready});
            if (n == 1)  seen_rk1  = rk;
            if (n == 10) seen_rk10 = rk;
            cyc();
            budget++;
            if (rk_ready) n++;
        end
        start    = 1'b0;
        rk_ready = 1'b1;
        if (budget >= BUDGET) check_val("timeout", 128'd1, 128'd0);
        if (mode == 0) check_val("latency", 128'(budget), 128'd11);
        check_val("post_valid", {127'b0, rk_valid}, 128'd0);
        check_val("post_busy", {127'b0, busy}, 128'd0);
        check_val("post_done", {127'b0, done}, 128'd0);
        check_val("post_idx", {124'b0, rk_idx}, 128'd10);
        check_val("post_rk", rk, model_rk[10]);
        n_exp++;
        $display("expansion %0d key=%h rk10=%h cycles=%0d", n_exp, key, rk, budget);
    endtask

    task automatic reset_mid_test(input logic [127:0] key);
        build_model(key);
        key_in = key;
        start  = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 0; n < 6; n++) cyc();
        check_val("pre_rst_idx", {124'b0, rk_idx}, 128'd6);
        check_val("pre_rst_rk", rk, model_rk[6]);
        rst_n    = 1'b0;
        start    = 1'b1;
        rk_ready = 1'b1;
        cyc();
        rst_n = 1'b1;
        start = 1'b0;
        check_val("rst_valid", {127'b0, rk_valid}, 128'd0);
        check_val("rst_busy", {127'b0, busy}, 128'd0);
        check_val("rst_done", {127'b0, done}, 128'd0);
        check_val("rst_rk", rk, 128'd0);
        check_val("rst_idx", {124'b0, rk_idx}, 128'd0);
        cyc();
        check_val("rst_nostart", {127'b0, rk_valid}, 128'd0);
        $display("mid-expansion reset at idx 6, key=%h", key);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_val("reset_valid", {127'b0, rk_valid}, 128'd0);
        check_val("reset_busy", {127'b0, busy}, 128'd0);
        check_val("reset_done", {127'b0, done}, 128'd0);
        check_val("reset_idx", {124'b0, rk_idx}, 128'd0);
        check_val("reset_rk", rk, 128'd0);
        rst_n = 1'b1;
        cyc();
        check_val("idle_valid", {127'b0, rk_valid}, 128'd0);

        run_expand(KAT1_KEY, 0, 1'b0);
        check_val("kat1_rk1", seen_rk1, KAT1_RK1);
        check_val("kat1_rk10", seen_rk10, KAT1_RK10);
        // Back-to-back start in the cycle after o_done.
        run_expand(128'd0, 0, 1'b0);
        check_val("kat2_rk1", seen_rk1, KAT2_RK1);
        check_val("kat2_rk10", seen_rk10, KAT2_RK10);
        run_expand(rand_key(), 0, 1'b1);

        cyc();
        reset_mid_test(rand_key());
        run_expand(rand_key(), 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
`ifdef KEY_EXPAND_STALL_EN
            run_expand(rand_key(), 1, i[0]);
`else
            run_expand(rand_key(), 0, i[0]);
`endif
        end

`ifdef KEY_EXPAND_STALL_EN
        run_expand(KAT1_KEY, 2, 1'b0);
        check_val("stall_kat_rk1", seen_rk1, KAT1_RK1);
        check_val("stall_kat_rk10", seen_rk10, KAT1_RK10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
